// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyph helpers for the 7-segment display controller.
//   state_t     controller FSM states (IDLE, CONV, LOAD)
//   SEG_BLANK   all segments off, active-high form
//   SEG_DASH    '-' (segment g only), active-high form
//   seg7_glyph  4-bit value -> active-high segment pattern, bit0=a .. bit6=g
// Polarity is applied by the top level at its output register only.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   function automatic logic [6:0] seg7_glyph(input logic [3:0] val);
      logic [6:0] seg;
      case (val)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_bcd_conv.sv
// seg7_bcd_conv: iterative double-dabble binary -> BCD converter.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   start_i    load bin_i and begin a conversion (DATA_W steps follow)
//   bin_i      unsigned binary input
//   done_o     high in the cycle whose closing edge performs the final step;
//              bcd_o holds the finished result from the following cycle on
//   bcd_o      BCD result, BCD_DIGITS digits, digit 0 in the low nibble
module seg7_bcd_conv #(
   parameter int DATA_W     = 20,
   parameter int BCD_DIGITS = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [DATA_W-1:0]       bin_i,
   output logic                    done_o,
   output logic [4*BCD_DIGITS-1:0] bcd_o
);

   localparam int BW    = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [BW-1:0]     adj_s;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Add-3 correction on every BCD digit >= 5 before the shift.
   always_comb begin
      adj_s = bcd_q;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) begin
            adj_s[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
         end else begin
            adj_s[4*d +: 4] = bcd_q[4*d +: 4];
         end
      end
   end

   // Next-state: load on start, otherwise one shift step per cycle until the count expires.
   always_comb begin
      bin_d = bin_q;
      bcd_d = bcd_q;
      cnt_d = cnt_q;
      if (start_i) begin
         bin_d = bin_i;
         bcd_d = '0;
         cnt_d = CNT_W'(DATA_W);
      end else if (cnt_q != '0) begin
         bin_d = bin_q << 1;
         bcd_d = {adj_s[BW-2:0], bin_q[DATA_W-1]};
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Converter state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else begin
         bin_q <= bin_d;
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CNT_W'(1));
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: multi-digit 7-segment display controller.
//   CLOCK50     system clock          RESET_N    async active-low reset
//   in_valid    value offered         in_ready   controller idle, can accept
//   in_data     unsigned value        in_mode    0 = hex, 1 = decimal
//   blank_lz    live leading-zero blanking
//   blink_en    live blink enable     blink_mask digits that blink
//   hex_out     registered segments, digit d at [7d+6:7d], bit0=a .. bit6=g
//   busy        = !in_ready           overflow   last decimal value too wide
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int DATA_W     = 20,
   parameter int BLINK_DIV  = 25_000_000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    CLOCK50,
   input  logic                    RESET_N,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_mode,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [7*NUM_DIGITS-1:0] hex_out,
   output logic                    busy,
   output logic                    overflow
);

   localparam int DIG_W      = 4 * NUM_DIGITS;
   localparam int BCD_DIGITS = NUM_DIGITS + 2;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int HEX_W      = 7 * NUM_DIGITS;
   localparam int BLK_W      = $clog2(BLINK_DIV);
   localparam logic [HEX_W-1:0] HEX_RESET = (ACTIVE_LOW != 0) ? {NUM_DIGITS{7'h7F}} : '0;

   state_t           state_q, state_d;
   logic [DIG_W-1:0] data_q, data_d;
   logic             mode_q, mode_d;
   logic [DIG_W-1:0] dig_q, dig_d;
   logic             shown_q, shown_d;   // digit register holds a loaded value
   logic             ovf_q, ovf_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             phase_q, phase_d;
   logic [HEX_W-1:0] hex_q, hex_d;

   logic             conv_done_s;
   logic [BCD_W-1:0] bcd_s;
   logic             higher_nz_s;
   logic [3:0]       nib_s;
   logic [6:0]       seg_s;

   seg7_bcd_conv #(
      .DATA_W     (DATA_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bcd (
      .clk_i   (CLOCK50),
      .rst_ni  (RESET_N),
      .start_i (in_valid & in_ready & in_mode),
      .bin_i   (in_data),
      .done_o  (conv_done_s),
      .bcd_o   (bcd_s)
   );

   // FSM next-state, input capture and digit-register update.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      dig_d   = dig_q;
      shown_d = shown_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = DIG_W'(in_data);
               mode_d  = in_mode;
               state_d = in_mode ? CONV : LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            if (conv_done_s) begin
               state_d = LOAD;
            end else begin
               state_d = CONV;
            end
         end
         LOAD: begin
            shown_d = 1'b1;
            state_d = IDLE;
            if (mode_q) begin
               // Any nonzero digit above the displayable range is an overflow.
               dig_d = bcd_s[DIG_W-1:0];
               ovf_d = |bcd_s[BCD_W-1:DIG_W];
            end else begin
               dig_d = data_q;
               ovf_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running blink counter; phase flips on each wrap.
   always_comb begin
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
         blk_cnt_d = '0;
         phase_d   = ~phase_q;
      end else begin
         blk_cnt_d = blk_cnt_q + BLK_W'(1);
         phase_d   = phase_q;
      end
   end

   // Glyph selection with overflow, leading-zero and blink blanking, MSD first.
   always_comb begin
      hex_d       = '0;
      higher_nz_s = 1'b0;
      nib_s       = 4'd0;
      seg_s       = SEG_BLANK;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         nib_s       = dig_q[4*d +: 4];
         higher_nz_s = higher_nz_s | (nib_s != 4'd0);
         if (!shown_q) begin
            seg_s = SEG_BLANK;
         end else if (blink_en && phase_q && blink_mask[d]) begin
            seg_s = SEG_BLANK;
         end else if (ovf_q) begin
            seg_s = SEG_DASH;
         end else if (blank_lz && !higher_nz_s && (d != 0)) begin
            seg_s = SEG_BLANK;
         end else begin
            seg_s = seg7_glyph(nib_s);
         end
         hex_d[7*d +: 7] = (ACTIVE_LOW != 0) ? ~seg_s : seg_s;
      end
   end

   // State, digit register, blink and output registers.
   always_ff @(posedge CLOCK50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         data_q    <= '0;
         mode_q    <= 1'b0;
         dig_q     <= '0;
         shown_q   <= 1'b0;
         ovf_q     <= 1'b0;
         blk_cnt_q <= '0;
         phase_q   <= 1'b0;
         hex_q     <= HEX_RESET;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         mode_q    <= mode_d;
         dig_q     <= dig_d;
         shown_q   <= shown_d;
         ovf_q     <= ovf_d;
         blk_cnt_q <= blk_cnt_d;
         phase_q   <= phase_d;
         hex_q     <= hex_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = ~in_ready;
   assign overflow = ovf_q;
   assign hex_out  = hex_q;

endmodule
